// File: rtl/csc_dec_deadlock_watchdog_ctrl_if.sv
// Report channel from the deadlock watchdog to the debug/status logic.
// The master drives the report, the slave returns ready.
interface csc_dec_deadlock_watchdog_ctrl_if #(
  parameter int N_MON = 4,
  parameter int CNT_W = 16
);
  logic             report_valid;
  logic             report_ready;
  logic [N_MON-1:0] report_mask;
  logic [4:0]       report_index;
  logic [CNT_W-1:0] report_cycles;

  modport master (
    output report_valid,
    output report_mask,
    output report_index,
    output report_cycles,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_mask,
    input  report_index,
    input  report_cycles,
    output report_ready
  );
endinterface

// File: rtl/csc_dec_deadlock_watchdog_ctrl.sv
// Deadlock watchdog for the csc_dec monitor tree: confirms a persistent stall,
// reports it once over a valid/ready channel and holds a sticky interrupt.
module csc_dec_deadlock_watchdog_ctrl #(
  parameter int N_MON = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic [N_MON-1:0]      block_sigs_i,
  input  logic                  progress_i,
  input  logic [CNT_W-1:0]      timeout_cycles_i,
  input  logic                  irq_clear_i,
  csc_dec_deadlock_watchdog_ctrl_if.master report,
  output logic                  deadlock_irq_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WATCH   = 3'd1,
    CONFIRM = 3'd2,
    REPORT  = 3'd3,
    HOLD    = 3'd4
  } state_e;

  state_e           state_q;
  logic [N_MON-1:0] persistMask_q;
  logic [CNT_W-1:0] count_q;
  logic             reportValid_q;
  logic             irq_q;
  logic [N_MON-1:0] reportMask_q;
  logic [4:0]       reportIndex_q;
  logic [CNT_W-1:0] reportCycles_q;

  logic [N_MON-1:0] keptMask_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] timeoutEff;
  logic             stallBroken;

  function automatic logic [4:0] lowestIdx(input logic [N_MON-1:0] m);
    logic [4:0] idx;
    idx = '0;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (m[i]) idx = i[4:0];
    end
    return idx;
  endfunction

  // A zero timeout behaves as one cycle; the stall counter saturates instead of wrapping.
  assign keptMask_d  = persistMask_q & block_sigs_i;
  assign timeoutEff  = (timeout_cycles_i == '0) ? CNT_W'(1) : timeout_cycles_i;
  assign count_d     = (&count_q) ? count_q : count_q + CNT_W'(1);
  assign stallBroken = progress_i || !enable_i || (keptMask_d == '0);

  // The confirmation fires once the count already reached the window, so the
  // reported stall length equals the window and valid rises T+1 cycles after the first block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      persistMask_q  <= '0;
      count_q        <= '0;
      reportValid_q  <= 1'b0;
      irq_q          <= 1'b0;
      reportMask_q   <= '0;
      reportIndex_q  <= '0;
      reportCycles_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) state_q <= WATCH;
        end
        WATCH: begin
          count_q <= '0;
          if (!enable_i) begin
            state_q <= IDLE;
          end else if ((|block_sigs_i) && !progress_i) begin
            persistMask_q <= block_sigs_i;
            count_q       <= CNT_W'(1);
            state_q       <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (stallBroken) begin
            count_q       <= '0;
            persistMask_q <= '0;
            state_q       <= enable_i ? WATCH : IDLE;
          end else if (count_q >= timeoutEff) begin
            reportMask_q   <= keptMask_d;
            reportIndex_q  <= lowestIdx(keptMask_d);
            reportCycles_q <= count_q;
            reportValid_q  <= 1'b1;
            count_q        <= '0;
            persistMask_q  <= '0;
            state_q        <= REPORT;
          end else begin
            persistMask_q <= keptMask_d;
            count_q       <= count_d;
          end
        end
        REPORT: begin
          if (report.report_ready) begin
            reportValid_q <= 1'b0;
            irq_q         <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (irq_clear_i) begin
            irq_q   <= 1'b0;
            state_q <= enable_i ? WATCH : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign report.report_valid  = reportValid_q;
  assign report.report_mask   = reportMask_q;
  assign report.report_index  = reportIndex_q;
  assign report.report_cycles = reportCycles_q;
  assign deadlock_irq_o       = irq_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_csc_dec_deadlock_watchdog_ctrl.sv
// Bench for the deadlock watchdog: directed scenarios with literal expectations,
// then random traffic compared every cycle against a stall-history model.
module tb_csc_dec_deadlock_watchdog_ctrl;

  localparam int N_MON = 4;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [N_MON-1:0] blockSigs;
  logic             progress;
  logic [CNT_W-1:0] timeoutCycles;
  logic             irqClear;
  logic             deadlockIrq;
  logic [2:0]       stateO;

  csc_dec_deadlock_watchdog_ctrl_if #(.N_MON(N_MON), .CNT_W(CNT_W)) rptIf ();

  csc_dec_deadlock_watchdog_ctrl #(.N_MON(N_MON), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable_i         (enable),
    .block_sigs_i     (blockSigs),
    .progress_i       (progress),
    .timeout_cycles_i (timeoutCycles),
    .irq_clear_i      (irqClear),
    .report           (rptIf),
    .deadlock_irq_o   (deadlockIrq),
    .state_o          (stateO)
  );

  always #5 clock = ~clock;

  int nVec = 0;
  int nMis = 0;
  logic checkEn = 1'b0;

  // Model: the stall is kept as the list of block samples seen since it began.
  int               mMode;
  logic [N_MON-1:0] stallQ[$];
  logic             expValid, expIrq;
  logic [N_MON-1:0] expMask;
  logic [4:0]       expIdx;
  logic [CNT_W-1:0] expCycles;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    logic [N_MON-1:0] common;
    int t, idx;
    if (reset) begin
      mMode = 0; stallQ.delete();
      expValid = 0; expIrq = 0; expMask = '0; expIdx = '0; expCycles = '0;
    end else begin
      case (mMode)
        0: if (enable) mMode = 1;
        1: begin
          if (!enable) mMode = 0;
          else if (blockSigs != 0 && !progress) begin
            stallQ = {blockSigs};
            mMode = 2;
          end
        end
        2: begin
          common = blockSigs;
          foreach (stallQ[i]) common &= stallQ[i];
          t = (timeoutCycles == 0) ? 1 : int'(timeoutCycles);
          if (progress || !enable || common == 0) begin
            stallQ.delete();
            mMode = enable ? 1 : 0;
          end else if (stallQ.size() >= t) begin
            idx = 0;
            while (!common[idx]) idx++;
            expMask   = common;
            expIdx    = 5'(idx);
            expCycles = (stallQ.size() > 65535) ? 16'hFFFF : 16'(stallQ.size());
            expValid  = 1;
            stallQ.delete();
            mMode = 3;
          end else begin
            stallQ.push_back(blockSigs);
          end
        end
        3: if (rptIf.report_ready) begin
          expValid = 0; expIrq = 1; mMode = 4;
        end
        4: if (irqClear) begin
          expIrq = 0; mMode = enable ? 1 : 0;
        end
        default: mMode = 0;
      endcase
    end
  endtask

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("valid", 32'(rptIf.report_valid), 32'(expValid));
      checkOutput("irq", 32'(deadlockIrq), 32'(expIrq));
      checkOutput("state", 32'(stateO), 32'(mMode));
      checkOutput("mask", 32'(rptIf.report_mask), 32'(expMask));
      checkOutput("index", 32'(rptIf.report_index), 32'(expIdx));
      checkOutput("cycles", 32'(rptIf.report_cycles), 32'(expCycles));
    end
  end

  task automatic tick();
    @(posedge clock);
    modelStep();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic en, input logic [N_MON-1:0] blk, input logic prog,
                               input logic [CNT_W-1:0] t, input logic clr, input logic rdy);
    enable = en; blockSigs = blk; progress = prog;
    timeoutCycles = t; irqClear = clr; rptIf.report_ready = rdy;
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    while (!rptIf.report_valid && n < limit) begin
      tick();
      n++;
    end
    if (!rptIf.report_valid) checkOutput("validTimeout", 32'(rptIf.report_valid), 32'd1);
  endtask

  task automatic finishReport(input logic [CNT_W-1:0] t);
    applyStimulus(1, 4'b0000, 0, t, 0, 1);
    tick();
    checkOutput("hsIrq", 32'(deadlockIrq), 32'd1);
    checkOutput("hsState", 32'(stateO), 32'd4);
    applyStimulus(1, 4'b0000, 0, t, 1, 0);
    tick();
    irqClear = 0;
    checkOutput("clrIrq", 32'(deadlockIrq), 32'd0);
    checkOutput("clrState", 32'(stateO), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: simulation did not end, expected finish");
    $fatal(1, "[TB] global time limit");
  end

  initial begin
    int n;
    logic [N_MON-1:0] heldMask;
    reset = 1;
    applyStimulus(0, 4'b0000, 0, 16'd0, 0, 0);
    tick();
    checkEn = 1;
    tick();
    reset = 0;
    checkOutput("rstValid", 32'(rptIf.report_valid), 32'd0);
    checkOutput("rstIrq", 32'(deadlockIrq), 32'd0);
    checkOutput("rstState", 32'(stateO), 32'd0);

    // Scenario 1: constant single-monitor stall, window 8
    applyStimulus(1, 4'b0000, 0, 16'd8, 0, 0);
    tick();
    checkOutput("armState", 32'(stateO), 32'd1);
    blockSigs = 4'b0100;
    waitValid(40, n);
    checkOutput("s1Latency", 32'(n), 32'd9);
    checkOutput("s1Mask", 32'(rptIf.report_mask), 32'h4);
    checkOutput("s1Index", 32'(rptIf.report_index), 32'd2);
    checkOutput("s1Cycles", 32'(rptIf.report_cycles), 32'd8);
    finishReport(16'd8);

    // Scenario 2: progress at cycle 5 restarts confirmation
    applyStimulus(1, 4'b0100, 0, 16'd8, 0, 0);
    repeat (5) tick();
    progress = 1;
    tick();
    progress = 0;
    checkOutput("s2State", 32'(stateO), 32'd1);
    checkOutput("s2Valid", 32'(rptIf.report_valid), 32'd0);
    waitValid(40, n);
    checkOutput("s2Latency", 32'(n), 32'd9);
    finishReport(16'd8);

    // Scenario 3: shrinking mask, then a mask that empties
    applyStimulus(1, 4'b0110, 0, 16'd4, 0, 0);
    repeat (3) tick();
    blockSigs = 4'b0100;
    waitValid(40, n);
    checkOutput("s3Latency", 32'(n), 32'd2);
    checkOutput("s3Mask", 32'(rptIf.report_mask), 32'h4);
    checkOutput("s3Index", 32'(rptIf.report_index), 32'd2);
    checkOutput("s3Cycles", 32'(rptIf.report_cycles), 32'd4);
    finishReport(16'd4);
    applyStimulus(1, 4'b0110, 0, 16'd4, 0, 0);
    repeat (2) tick();
    blockSigs = 4'b0000;
    tick();
    checkOutput("s3Abort", 32'(stateO), 32'd1);

    // Scenario 4: back-pressure holds the report stable
    applyStimulus(1, 4'b1000, 0, 16'd2, 0, 0);
    waitValid(40, n);
    heldMask = rptIf.report_mask;
    checkOutput("s4Mask", 32'(heldMask), 32'h8);
    checkOutput("s4Index", 32'(rptIf.report_index), 32'd3);
    checkOutput("s4Cycles", 32'(rptIf.report_cycles), 32'd2);
    blockSigs = 4'b0001;
    repeat (5) begin
      tick();
      checkOutput("s4Stable", 32'(rptIf.report_mask), 32'(heldMask));
    end
    finishReport(16'd2);

    // Scenario 5: zero timeout, then disarm during confirmation
    applyStimulus(1, 4'b0001, 0, 16'd0, 0, 0);
    waitValid(40, n);
    checkOutput("s5Latency", 32'(n), 32'd2);
    checkOutput("s5Cycles", 32'(rptIf.report_cycles), 32'd1);
    finishReport(16'd0);
    applyStimulus(1, 4'b0001, 0, 16'd5, 0, 0);
    repeat (2) tick();
    enable = 0;
    tick();
    checkOutput("s5Idle", 32'(stateO), 32'd0);
    repeat (6) tick();
    checkOutput("s5NoRpt", 32'(rptIf.report_valid), 32'd0);

    // Scenario 6: reset while reporting and while holding
    applyStimulus(1, 4'b0010, 0, 16'd1, 0, 0);
    waitValid(40, n);
    reset = 1;
    tick();
    reset = 0;
    checkOutput("s6RptValid", 32'(rptIf.report_valid), 32'd0);
    checkOutput("s6RptState", 32'(stateO), 32'd0);
    waitValid(40, n);
    rptIf.report_ready = 1;
    tick();
    rptIf.report_ready = 0;
    checkOutput("s6HoldIrq", 32'(deadlockIrq), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    checkOutput("s6RstIrq", 32'(deadlockIrq), 32'd0);
    checkOutput("s6RstState", 32'(stateO), 32'd0);
    checkOutput("s6RstMask", 32'(rptIf.report_mask), 32'd0);

    // Random traffic: sticky block patterns, sparse progress and resets
    applyStimulus(1, 4'b0000, 0, 16'd3, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(199) == 0);
      enable   = ($urandom_range(9) != 0);
      if ($urandom_range(5) == 0) blockSigs = N_MON'($urandom_range(15));
      progress = ($urandom_range(15) == 0);
      if ($urandom_range(19) == 0) timeoutCycles = CNT_W'($urandom_range(10));
      irqClear = ($urandom_range(7) == 0);
      rptIf.report_ready = ($urandom_range(2) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
